// File: rtl/alu_wb_stage.sv
// ALU write-back stage: 2-entry result buffer between the ALU and the register-file
// write port, with architectural flag update, sticky overflow and a commit counter.
module alu_wb_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_y,
    input  logic [3:0]       in_op,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic             in_zero,
    input  logic             in_negative,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [3:0]       out_op,
    output logic [3:0]       flags,
    output logic             sticky_v,
    input  logic             clr_sticky,
    output logic [15:0]      commit_cnt
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [WIDTH-1:0] y_q   [2];
    logic [WIDTH-1:0] y_d   [2];
    logic [3:0]       op_q  [2];
    logic [3:0]       op_d  [2];
    logic [3:0]       flg_q [2];   // stored as {N,Z,C,V}
    logic [3:0]       flg_d [2];

    logic [1:0]  occ_q, occ_d;
    logic        head_q, head_d;
    logic        in_ready_q, in_ready_d;
    logic [3:0]  flags_q, flags_d;
    logic        sticky_q, sticky_d;
    logic [15:0] cnt_q, cnt_d;

    logic        push, pop, tail, is_shift;
    logic [3:0]  head_flg;
    logic [3:0]  head_op;

    assign push     = in_valid && in_ready_q;
    assign pop      = (occ_q != 2'd0) && out_ready;
    assign tail     = head_q ^ occ_q[0];
    assign head_flg = flg_q[head_q];
    assign head_op  = op_q[head_q];
    assign is_shift = (head_op == 4'h5) || (head_op == 4'h6) || (head_op == 4'h7);

    always_comb begin
        y_d    = y_q;
        op_d   = op_q;
        flg_d  = flg_q;
        occ_d  = occ_q;
        head_d = head_q;
        flags_d  = flags_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;

        if (push) begin
            y_d[tail]   = in_y;
            op_d[tail]  = in_op;
            flg_d[tail] = {in_negative, in_zero, in_carry, in_overflow};
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        if (clr_sticky)
            sticky_d = 1'b0;

        if (pop) begin
            head_d = ~head_q;
            cnt_d  = cnt_q + 16'd1;
            // shifts leave C and V untouched and never feed the sticky overflow
            if (is_shift) begin
                flags_d = {head_flg[3:2], flags_q[1:0]};
            end else begin
                flags_d = head_flg;
                if (head_flg[0])
                    sticky_d = 1'b1;
            end
        end

        in_ready_d = (occ_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                y_q[i]   <= '0;
                op_q[i]  <= '0;
                flg_q[i] <= '0;
            end
            occ_q      <= 2'd0;
            head_q     <= 1'b0;
            in_ready_q <= 1'b0;
            flags_q    <= 4'b0000;
            sticky_q   <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            y_q        <= y_d;
            op_q       <= op_d;
            flg_q      <= flg_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            in_ready_q <= in_ready_d;
            flags_q    <= flags_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (occ_q != 2'd0);
    assign out_y      = y_q[head_q];
    assign out_op     = op_q[head_q];
    assign flags      = flags_q;
    assign sticky_v   = sticky_q;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage.
module tb_alu_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_y;
    logic [3:0]  in_op;
    logic        in_carry, in_overflow, in_zero, in_negative;
    logic        out_valid, out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_op;
    logic [3:0]  flags;
    logic        sticky_v, clr_sticky;
    logic [15:0] commit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    alu_wb_stage #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y), .in_op(in_op),
        .in_carry(in_carry), .in_overflow(in_overflow), .in_zero(in_zero),
        .in_negative(in_negative),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op),
        .flags(flags), .sticky_v(sticky_v), .clr_sticky(clr_sticky),
        .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] y, input logic [3:0] op,
                          input logic n, input logic z, input logic c, input logic ov);
        in_valid = v; in_y = y; in_op = op;
        in_negative = n; in_zero = z; in_carry = c; in_overflow = ov;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0; clr_sticky = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_y !== 32'h0) begin n_err++; $display("FAIL rst_out_y got %h want 0", out_y); end
        n_cmp++; if (out_op !== 4'h0) begin n_err++; $display("FAIL rst_out_op got %h want 0", out_op); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL rst_flags got %b want 0000", flags); end
        n_cmp++; if (sticky_v !== 1'b0) begin n_err++; $display("FAIL rst_sticky got %b want 0", sticky_v); end
        n_cmp++; if (commit_cnt !== 16'h0) begin n_err++; $display("FAIL rst_cnt got %h want 0", commit_cnt); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_first_edge_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single_pass();
        set_in(1'b1, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sp_no_bypass got %b want 0", out_valid); end
        tick();
        set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sp_out_valid got %b want 1", out_valid); end
        n_cmp++; if (out_y !== 32'h0) begin n_err++; $display("FAIL sp_out_y got %h want 0", out_y); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL sp_flags_precommit got %b want 0000", flags); end
        tick();
        n_cmp++; if (flags !== 4'b0110) begin n_err++; $display("FAIL sp_flags got %b want 0110", flags); end
        n_cmp++; if (commit_cnt !== 16'd1) begin n_err++; $display("FAIL sp_cnt got %0d want 1", commit_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sp_drained got %b want 0", out_valid); end
        tick();
        n_cmp++; if (commit_cnt !== 16'd1) begin n_err++; $display("FAIL sp_idle_cnt got %0d want 1", commit_cnt); end
    endtask

    task automatic test_shift_retention();
        out_ready = 1'b1;
        set_in(1'b1, 32'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(1'b1, 32'hFFFF_FFFC, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (out_op !== 4'h0) begin n_err++; $display("FAIL sh_head_op got %h want 0", out_op); end
        tick();
        set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (flags !== 4'b0011) begin n_err++; $display("FAIL sh_flags_add got %b want 0011", flags); end
        n_cmp++; if (out_y !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL sh_head_y got %h want fffffffc", out_y); end
        n_cmp++; if (out_op !== 4'h7) begin n_err++; $display("FAIL sh_head_op2 got %h want 7", out_op); end
        tick();
        n_cmp++; if (flags !== 4'b1011) begin n_err++; $display("FAIL sh_flags_sra got %b want 1011", flags); end
        n_cmp++; if (sticky_v !== 1'b1) begin n_err++; $display("FAIL sh_sticky got %b want 1", sticky_v); end
        n_cmp++; if (commit_cnt !== 16'd3) begin n_err++; $display("FAIL sh_cnt got %0d want 3", commit_cnt); end
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        n_cmp++; if (sticky_v !== 1'b0) begin n_err++; $display("FAIL sh_clr got %b want 0", sticky_v); end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        logic [31:0] exp_v[3];
        logic        sent3;
        exp_v[0] = 32'h10; exp_v[1] = 32'h20; exp_v[2] = 32'h30;
        out_ready = 1'b0;
        set_in(1'b1, 32'h10, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_occ1 got %b want 1", in_ready); end
        in_y = 32'h20;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %b want 0", in_ready); end
        in_y = 32'h30;
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_still_full got %b want 0", in_ready); end
        n_cmp++; if (out_y !== 32'h10) begin n_err++; $display("FAIL bp_head_stable got %h want 10", out_y); end
        out_ready = 1'b1;
        sent3 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) got.push_back(out_y);
            if (in_valid && in_ready) sent3 = 1'b1;
            tick();
            if (sent3) in_valid = 1'b0;
        end
        n_cmp++; if (got.size() != 3) begin n_err++; $display("FAIL bp_count got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                n_cmp++; if (got[i] !== exp_v[i]) begin n_err++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], exp_v[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        set_in(1'b1, 32'd100, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_y = 32'd101 + 32'(i);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
            n_cmp++; if (out_y !== 32'd100 + 32'(i)) begin n_err++; $display("FAIL b2b_y[%0d] got %0d want %0d", i, out_y, 100 + i); end
            tick();
        end
        n_cmp++; if (commit_cnt !== 16'd8) begin n_err++; $display("FAIL b2b_cnt got %0d want 8", commit_cnt); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_occ1 got %b want 1", out_valid); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_sticky_race();
        out_ready = 1'b0;
        set_in(1'b1, 32'h8000_0000, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        clr_sticky = 1'b1;
        tick();
        n_cmp++; if (sticky_v !== 1'b1) begin n_err++; $display("FAIL race_set_wins got %b want 1", sticky_v); end
        n_cmp++; if (flags !== 4'b0001) begin n_err++; $display("FAIL race_flags got %b want 0001", flags); end
        tick();
        clr_sticky = 1'b0;
        n_cmp++; if (sticky_v !== 1'b0) begin n_err++; $display("FAIL race_clear got %b want 0", sticky_v); end
    endtask

    task automatic test_reset_midstream();
        int guard;
        out_ready = 1'b0;
        set_in(1'b1, 32'hA, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL mid_flags got %b want 0000", flags); end
        n_cmp++; if (commit_cnt !== 16'h0) begin n_err++; $display("FAIL mid_cnt got %h want 0", commit_cnt); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_discard got %b want 0", out_valid); end
        n_cmp++; if (commit_cnt !== 16'h0) begin n_err++; $display("FAIL mid_no_commit got %h want 0", commit_cnt); end
        set_in(1'b1, 32'h5, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        guard = 0;
        while (commit_cnt !== 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        n_cmp++; if (commit_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_reach got %h want ffff", commit_cnt); end
        tick();
        n_cmp++; if (commit_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h want 0000", commit_cnt); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_shift_retention();
        test_backpressure();
        test_back_to_back();
        test_sticky_race();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width of the ALU result.
REQ-002 Parameter: DEPTH, default 2, result buffer entries; only 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream ALU result present.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 in_y  input  WIDTH  ALU result y.
REQ-008 in_op  input  4  opcode that produced in_y.
REQ-009 in_carry, in_overflow, in_zero, in_negative  input  1 each  ALU flags C, V, Z, N.
REQ-010 out_valid  output  1  committed-side result available.
REQ-011 out_ready  input  1  downstream (register-file write port) accepts.
REQ-012 out_y  output  WIDTH  buffered result at buffer head.
REQ-013 out_op  output  4  opcode of buffer head.
REQ-014 flags  output  4  architectural flags {N,Z,C,V}, updated on commit.
REQ-015 sticky_v  output  1  sticky overflow, set by any committed V=1.
REQ-016 clr_sticky  input  1  synchronous clear of sticky_v.
REQ-017 commit_cnt  output  16  number of committed results, wraps.

Function
REQ-018 Accept: transfer when in_valid && in_ready; payload {in_y, in_op, C, V, Z, N} written to buffer tail.
REQ-019 Commit: transfer when out_valid && out_ready; head entry popped.
REQ-020 Buffer is a 2-entry FIFO; in_ready = (occupancy < 2), registered from occupancy, no combinational path from out_ready.
REQ-021 out_valid = (occupancy > 0); out_y/out_op driven from head entry, stable while out_valid && !out_ready.
REQ-022 Latency: result accepted in cycle k is visible on out_valid/out_y in cycle k+1 at earliest; no same-cycle bypass.
REQ-023 Simultaneous accept and commit with occupancy 1: occupancy stays 1, new entry becomes head next cycle.
REQ-024 Occupancy 2: in_ready=0; commit in that cycle frees a slot, in_ready=1 next cycle.
REQ-025 Occupancy 0 with out_ready=1: no commit, no flag/counter change.
REQ-026 Flag update on commit only, using the committed entry's stored flags.
REQ-027 Committed op in {0x5 SLL, 0x6 SRL, 0x7 SRA}: update N and Z only; C and V retain previous value.
REQ-028 Any other committed op: update all of N, Z, C, V.
REQ-029 sticky_v: set on commit of a non-shift op with stored V=1; cleared on clr_sticky; set and clear in same cycle -> set wins.
REQ-030 commit_cnt increments by 1 per commit, 0xFFFF -> 0x0000 wrap, no saturation.
REQ-031 Buffer entries not in occupancy range are don't-care; out_y undefined-value-free: reset value holds until first write.

Reset
REQ-032 rst_n low asynchronously: occupancy=0, in_ready=0 during reset, out_valid=0, out_y=0, out_op=0, flags=4'b0000, sticky_v=0, commit_cnt=0.
REQ-033 First rising edge with rst_n high: in_ready=1.
REQ-034 Reset mid-operation discards buffered entries; no commit occurs in the reset cycle.

Verification
REQ-035 Single pass: accept op=0x0, y=0x0000_0000, C=1,V=0,Z=1,N=0 with out_ready=1 -> out_valid next cycle, y=0, then flags=4'b0110, commit_cnt=1.
REQ-036 Shift retention: commit op=0x0 with C=1,V=1 then op=0x7, y=0xFFFF_FFFC, N=1,Z=0,C=0,V=0 -> flags={N=1,Z=0,C=1,V=1}, sticky_v=1.
REQ-037 Backpressure: out_ready=0, push 3 results 0x10,0x20,0x30 -> third held (in_ready=0 after 2), then out_ready=1 -> outputs 0x10,0x20,0x30 in order, no loss or duplication.
REQ-038 Simultaneous push/pop at occupancy 1 over 8 cycles of continuous in_valid=out_ready=1 -> one commit per cycle, commit_cnt=8, in_ready constant 1.
REQ-039 Sticky race: commit non-shift op with V=1 while clr_sticky=1 -> sticky_v=1; next cycle clr_sticky=1 alone -> sticky_v=0.
REQ-040 Reset mid-stream: occupancy 2, assert rst_n=0 between edges -> out_valid=0, flags=0, commit_cnt=0 immediately; commit_cnt preset 0xFFFF scenario wraps to 0x0000 on next commit.
